rrv_imem_arb: RTL
=================

RRV_IMEM_ARB -- requirements
Module: rrv_imem_arb

Interface
REQ-001 Parameter ADDR_W, default 16, word address width of the shared instruction RAM.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Parameter STARVE_MAX, default 4, consecutive loader denials in RUN before the loader is forced a grant.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ld_req  in  1  loader/debug access request.
REQ-007 ld_we  in  1  loader write (1) or read (0), qualified by ld_req.
REQ-008 ld_addr  in  ADDR_W  loader word address.
REQ-009 ld_wdata  in  DATA_W  loader write data.
REQ-010 ld_done  in  1  program load complete; releases the core.
REQ-011 ld_halt  in  1  return RAM to loader ownership and hold the core.
REQ-012 ld_gnt  out  1  loader request accepted this cycle.
REQ-013 ld_rvalid / ld_rdata  out  1 / DATA_W  loader read data, one cycle after a granted read.
REQ-014 f_req / f_addr  in  1 / ADDR_W  fetch read request and word address.
REQ-015 f_gnt  out  1  fetch request accepted this cycle.
REQ-016 f_rvalid / f_rdata  out  1 / DATA_W  fetch read data, one cycle after grant.
REQ-017 ram_en / ram_we / ram_addr / ram_wdata  out  1 / 1 / ADDR_W / DATA_W  RAM port.
REQ-018 ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0.
REQ-019 core_hold  out  1  holds the core pipeline (fetch PC frozen) while 1.

Function
REQ-020 FSM states BOOT, RUN, DRAIN; BOOT after reset.
REQ-021 BOOT: ld_gnt = ld_req, f_gnt = 0, core_hold = 1.
REQ-022 BOOT -> RUN when ld_done=1; a ld_req in the same cycle is still granted.
REQ-023 RUN: core_hold = 0; fetch has priority: f_gnt = f_req unless forced loader grant; ld_gnt = ld_req & ~f_gnt.
REQ-024 starve_cnt increments each RUN cycle with ld_req=1 and ld_gnt=0, saturating at STARVE_MAX; clears on any ld_gnt.
REQ-025 Forced grant: in RUN, if starve_cnt == STARVE_MAX and ld_req=1, ld_gnt=1 and f_gnt=0 that cycle.
REQ-026 RUN -> DRAIN on ld_halt=1; DRAIN: core_hold = 1, no new grants; DRAIN -> BOOT next cycle (lets an outstanding read return).
REQ-027 ld_halt and ld_done both 1 in BOOT: ld_halt wins, remain BOOT.
REQ-028 Grants are combinational in the request cycle; ram_en = ld_gnt | f_gnt; ram_addr/ram_we/ram_wdata from the granted requester; ram_we = 0 for fetch.
REQ-029 Exactly one of ld_gnt, f_gnt may be 1 in any cycle.
REQ-030 A 1-bit owner register records the granted reader; next cycle the matching rvalid = 1 with rdata = ram_rdata; the other rvalid = 0.
REQ-031 Loader writes produce no rvalid.
REQ-032 rdata outputs are ram_rdata passthrough; value undefined when rvalid = 0.

Reset
REQ-033 rst=1 forces state BOOT, starve_cnt = 0, both rvalid = 0, core_hold = 1, all grants and ram_en = 0, immediately (asynchronous).
REQ-034 A read in flight at reset assertion is discarded; no rvalid after reset release.

Structure
REQ-035 State enum (BOOT, RUN, DRAIN) and owner enum (OWN_LD, OWN_FETCH) live in the shared rrv package.
REQ-036 Single module, no sub-modules; starve counter width $clog2(STARVE_MAX+1).

Verification
REQ-037 Reset, load words 0x00000013 to addresses 0..3 in BOOT, then ld_done -> four RAM writes, f_gnt stays 0, core_hold falls the cycle after ld_done.
REQ-038 RUN, f_req every cycle addr 0..7 -> f_gnt each cycle, f_rvalid one cycle later with the loaded data in order.
REQ-039 RUN, f_req and ld_req read addr 0x10 continuously, STARVE_MAX=4 -> ld_gnt on the 5th cycle only, f_gnt=0 that cycle, ld_rvalid the cycle after, then counter restarts.
REQ-040 RUN, ld_halt pulsed while fetch read outstanding -> f_rvalid delivered in DRAIN, core_hold=1, state BOOT one cycle later.
REQ-041 rst asserted mid-cycle after a fetch grant -> no f_rvalid, all outputs at reset values before the next clock edge.
REQ-042 Assertion on every cycle: ld_gnt & f_gnt never both 1; ram_we implies ld_gnt.

Source files
------------

// File: rtl/rrv_imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter.
package rrv_imem_arb_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_LD    = 1'b0,
    OWN_FETCH = 1'b1
  } owner_e;

endpackage

// File: rtl/rrv_imem_arb.sv
// Arbiter sharing one instruction RAM port between the program loader and core fetch.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  BOOT  | loader owns the RAM, core held; ld_done releases the core
//  RUN   | fetch has priority, loader forced in after STARVE_MAX denials
//  DRAIN | core held, no new grants; one cycle for an outstanding read
module rrv_imem_arb
  import rrv_imem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  input  logic              ld_halt,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              core_hold
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  owner_e           owner_q, owner_d;
  logic             rd_pend_q, rd_pend_d;
  logic             force_ld;

  // State, starvation counter and read-return bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      starve_q  <= '0;
      owner_q   <= OWN_LD;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Next state and combinational grants; grants are gated by rst so the
  // RAM port is quiet the instant reset is asserted.
  always_comb begin
    state_d   = state_q;
    ld_gnt    = 1'b0;
    f_gnt     = 1'b0;
    core_hold = 1'b1;
    force_ld  = 1'b0;
    case (state_q)
      BOOT: begin
        ld_gnt = ld_req;
        // halt outranks done so a loader can keep the core parked
        if (!ld_halt && ld_done) state_d = RUN;
      end
      RUN: begin
        core_hold = 1'b0;
        force_ld  = ld_req && (starve_q == STARVE_LIM);
        f_gnt     = f_req && !force_ld;
        ld_gnt    = ld_req && !f_gnt;
        if (ld_halt) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = BOOT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    if (rst) begin
      ld_gnt = 1'b0;
      f_gnt  = 1'b0;
    end
  end

  // Loader starvation counter: saturates in RUN, clears on any loader grant.
  always_comb begin
    starve_d = starve_q;
    if (ld_gnt) begin
      starve_d = '0;
    end else if (state_q == RUN && ld_req && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // RAM port mux and read-owner capture for the next-cycle return.
  always_comb begin
    ram_en    = ld_gnt | f_gnt;
    ram_we    = ld_gnt & ld_we;
    ram_addr  = f_gnt ? f_addr : ld_addr;
    ram_wdata = ld_wdata;
    rd_pend_d = ram_en & ~ram_we;
    owner_d   = f_gnt ? OWN_FETCH : OWN_LD;
  end

  assign f_rvalid  = rd_pend_q && (owner_q == OWN_FETCH);
  assign ld_rvalid = rd_pend_q && (owner_q == OWN_LD);
  assign f_rdata   = ram_rdata;
  assign ld_rdata  = ram_rdata;

endmodule
